// File: rtl/dino_game_ctrl.sv
// Game-flow controller for the dino runner: start/collision FSM, tick timer, BCD score, speed ramp.
// Optional best-score register is built only when DINO_HISCORE_EN is defined.
module dino_game_ctrl #(
    parameter int TICK_DIV   = 2000000,
    parameter int PASS_LIMIT = 12,
    parameter int MAX_SPEED  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        collision,
    input  logic        obstacle_wrap,
    output logic [1:0]  state,
    output logic        tick,
    output logic        load_positions,
    output logic [3:0]  obstacle_speed,
    output logic [19:0] score_bcd,
    output logic [1:0]  anim_phase,
    output logic [19:0] hiscore_bcd
);

    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_OVER = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic          start_q;
    logic [TW-1:0] timer_q, timer_d;
    logic          tick_q, tick_d;
    logic          load_q;
    logic [4:0]    pass_q, pass_d;
    logic [3:0]    speed_q, speed_d;
    logic [19:0]   score_q, score_d;
    logic [1:0]    phase_q, phase_d;

    logic start_edge;
    logic in_run;
    logic enter_run;
    logic leave_run;
    logic bcd_carry;

    assign start_edge = start_btn & ~start_q;
    assign in_run     = (state_q == S_RUN);
    assign enter_run  = ~in_run & start_edge;
    assign leave_run  = in_run & collision;
    // A collision on the tick cycle suppresses the tick so nothing advances as the game ends.
    assign tick       = tick_q & in_run & ~collision;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_edge) state_d = S_RUN;
            S_RUN:   if (collision)  state_d = S_OVER;
            S_OVER:  if (start_edge) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        timer_d   = '0;
        tick_d    = 1'b0;
        pass_d    = pass_q;
        speed_d   = speed_q;
        score_d   = score_q;
        phase_d   = phase_q;
        bcd_carry = 1'b1;
        if (in_run && !collision) begin
            if (timer_q == TW'(TICK_DIV - 1)) begin
                tick_d = 1'b1;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
        if (enter_run) begin
            pass_d  = '0;
            speed_d = 4'd1;
            score_d = '0;
            phase_d = '0;
        end else if (tick) begin
            for (int i = 0; i < 5; i++) begin
                if (bcd_carry) begin
                    if (score_q[4*i +: 4] == 4'd9) begin
                        score_d[4*i +: 4] = 4'd0;
                    end else begin
                        score_d[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                        bcd_carry         = 1'b0;
                    end
                end
            end
            phase_d = phase_q + 2'd1;
            if (obstacle_wrap) begin
                if (pass_q == 5'(PASS_LIMIT - 1)) begin
                    pass_d = '0;
                    if (speed_q != 4'(MAX_SPEED)) speed_d = speed_q + 4'd1;
                end else begin
                    pass_d = pass_q + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            timer_q <= '0;
            tick_q  <= 1'b0;
            load_q  <= 1'b0;
            pass_q  <= '0;
            speed_q <= 4'd1;
            score_q <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_btn;
            timer_q <= timer_d;
            tick_q  <= tick_d;
            load_q  <= enter_run;
            pass_q  <= pass_d;
            speed_q <= speed_d;
            score_q <= score_d;
            phase_q <= phase_d;
        end
    end

`ifdef DINO_HISCORE_EN
    logic [19:0] hiscore_q;

    // Valid BCD orders the same as binary, so a plain unsigned compare is enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hiscore_q <= '0;
        end else if (leave_run && (score_q > hiscore_q)) begin
            hiscore_q <= score_q;
        end
    end

    assign hiscore_bcd = hiscore_q;
`else
    assign hiscore_bcd = '0;
`endif

    assign state          = state_q;
    assign load_positions = load_q;
    assign obstacle_speed = speed_q;
    assign score_bcd      = score_q;
    assign anim_phase     = phase_q;

endmodule
